// File: rtl/rf_pkg.sv
// Shared constants and arbiter state encoding for the
// register-file write-port slice.
package rf_pkg;

  localparam int NUM_REG        = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int REG_WIDTH      = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    FORCE
  } arb_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-destination scoreboard for outstanding MCU results,
// with combinational RAW/WAW hazard lookup for decode.
module rf_scoreboard #(
  parameter int NUM_REG        = rf_pkg::NUM_REG,
  parameter int REG_ADDR_WIDTH = rf_pkg::REG_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_issue,
  input  logic [REG_ADDR_WIDTH-1:0] i_issue_rd,
  input  logic                      i_clr,
  input  logic [REG_ADDR_WIDTH-1:0] i_clr_rd,
  input  logic [REG_ADDR_WIDTH-1:0] i_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] i_rs2,
  output logic                      o_hazard
);

  logic [NUM_REG-1:0] r_pend;
  logic [NUM_REG-1:0] w_pend_nxt;

  // Set is applied after clear so a same-cycle reissue survives.
  always_comb begin
    w_pend_nxt = r_pend;
    if (i_clr)
      w_pend_nxt[i_clr_rd] = 1'b0;
    if (i_issue)
      w_pend_nxt[i_issue_rd] = 1'b1;
    w_pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_pend <= '0;
    else
      r_pend <= w_pend_nxt;
  end

  assign o_hazard = r_pend[i_rs1]
                  | r_pend[i_rs2]
                  | (i_issue & r_pend[i_issue_rd]);

endmodule

// File: rtl/rf_wport_arbiter.sv
// Shares the register-file write port between WB and the MCU,
// forcing a one-cycle pipeline stall when the MCU starves.
module rf_wport_arbiter #(
  parameter int NUM_REG        = rf_pkg::NUM_REG,
  parameter int REG_ADDR_WIDTH = rf_pkg::REG_ADDR_WIDTH,
  parameter int REG_WIDTH      = rf_pkg::REG_WIDTH,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wb_we,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
  input  logic [REG_WIDTH-1:0]      wb_data,
  input  logic                      mc_valid,
  input  logic [REG_ADDR_WIDTH-1:0] mc_rd,
  input  logic [REG_WIDTH-1:0]      mc_data,
  output logic                      mc_ready,
  input  logic                      mc_issue,
  input  logic [REG_ADDR_WIDTH-1:0] mc_issue_rd,
  input  logic [REG_ADDR_WIDTH-1:0] dec_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] dec_rs2,
  output logic                      dec_hazard,
  output logic                      pipe_stall,
  output logic                      rf_we,
  output logic [REG_ADDR_WIDTH-1:0] rf_addr,
  output logic [REG_WIDTH-1:0]      rf_data
);

  import rf_pkg::*;

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  arb_state_e r_state;
  arb_state_e w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  logic w_force;
  logic w_grant_mc;
  logic w_grant_wb;
  logic w_issue_set;
  logic [REG_ADDR_WIDTH-1:0] w_addr;
  logic [REG_WIDTH-1:0]      w_data;

  assign w_force    = (r_state == FORCE);
  assign w_grant_mc = rst_n & mc_valid & (~wb_we | w_force);
  assign w_grant_wb = rst_n & wb_we & ~w_grant_mc;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (mc_valid & wb_we) begin
          w_state_nxt = WAIT;
          w_cnt_nxt   = CW'(1);
        end
      end
      WAIT: begin
        if (~mc_valid | ~wb_we) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LIM) begin
          w_state_nxt = FORCE;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      FORCE: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_addr = '0;
    w_data = '0;
    unique case (1'b1)
      w_grant_mc: begin
        w_addr = mc_rd;
        w_data = mc_data;
      end
      w_grant_wb: begin
        w_addr = wb_rd;
        w_data = wb_data;
      end
      default: ;
    endcase
  end

  // x0 writes still handshake but never reach the array.
  assign rf_we      = (w_grant_mc | w_grant_wb) & (w_addr != '0);
  assign rf_addr    = w_addr;
  assign rf_data    = w_data;
  assign mc_ready   = w_grant_mc;
  assign pipe_stall = rst_n & w_force;

  assign w_issue_set = mc_issue & (mc_issue_rd != '0);

  rf_scoreboard #(
    .NUM_REG        (NUM_REG),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_issue    (w_issue_set),
    .i_issue_rd (mc_issue_rd),
    .i_clr      (w_grant_mc),
    .i_clr_rd   (mc_rd),
    .i_rs1      (dec_rs1),
    .i_rs2      (dec_rs2),
    .o_hazard   (dec_hazard)
  );

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Self-checking bench for rf_wport_arbiter: directed table,
// starvation/reset sequences, and randomized model comparison.
module tb_rf_wport_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mc_valid;
  logic [4:0]  mc_rd;
  logic [31:0] mc_data;
  logic        mc_ready;
  logic        mc_issue;
  logic [4:0]  mc_issue_rd;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic        dec_hazard;
  logic        pipe_stall;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] regs [32];

  always #5 clk = ~clk;

  rf_wport_arbiter #(
    .NUM_REG        (32),
    .REG_ADDR_WIDTH (5),
    .REG_WIDTH      (32),
    .STARVE_LIMIT   (LIMIT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wb_we       (wb_we),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .mc_valid    (mc_valid),
    .mc_rd       (mc_rd),
    .mc_data     (mc_data),
    .mc_ready    (mc_ready),
    .mc_issue    (mc_issue),
    .mc_issue_rd (mc_issue_rd),
    .dec_rs1     (dec_rs1),
    .dec_rs2     (dec_rs2),
    .dec_hazard  (dec_hazard),
    .pipe_stall  (pipe_stall),
    .rf_we       (rf_we),
    .rf_addr     (rf_addr),
    .rf_data     (rf_data)
  );

  // Register file model: samples the write port on negedge.
  always @(negedge clk)
    if (rf_we) regs[rf_addr] <= rf_data;

  typedef struct {
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mc_valid;
    logic [4:0]  mc_rd;
    logic [31:0] mc_data;
    logic        issue;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_rdy;
    logic        e_haz;
    logic        e_stall;
  } vec_t;

  vec_t tbl [15];

  function automatic vec_t mkv(
    input logic a_we, input logic [4:0] a_rd,
    input logic [31:0] a_d, input logic m_v,
    input logic [4:0] m_rd, input logic [31:0] m_d,
    input logic iss, input logic [4:0] iss_rd,
    input logic [4:0] r1, input logic [4:0] r2,
    input logic x_we, input logic [4:0] x_a,
    input logic [31:0] x_d, input logic x_r,
    input logic x_h, input logic x_s);
    vec_t v;
    v.wb_we = a_we; v.wb_rd = a_rd; v.wb_data = a_d;
    v.mc_valid = m_v; v.mc_rd = m_rd; v.mc_data = m_d;
    v.issue = iss; v.issue_rd = iss_rd;
    v.rs1 = r1; v.rs2 = r2;
    v.e_we = x_we; v.e_addr = x_a; v.e_data = x_d;
    v.e_rdy = x_r; v.e_haz = x_h; v.e_stall = x_s;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic a_we, input logic [4:0] a_rd,
                       input logic [31:0] a_d, input logic m_v,
                       input logic [4:0] m_rd, input logic [31:0] m_d,
                       input logic iss, input logic [4:0] iss_rd,
                       input logic [4:0] r1, input logic [4:0] r2);
    wb_we = a_we; wb_rd = a_rd; wb_data = a_d;
    mc_valid = m_v; mc_rd = m_rd; mc_data = m_d;
    mc_issue = iss; mc_issue_rd = iss_rd;
    dec_rs1 = r1; dec_rs2 = r2;
  endtask

  task automatic idle_in();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string p, input logic x_we,
                         input logic [4:0] x_a, input logic [31:0] x_d,
                         input logic x_r, input logic x_h,
                         input logic x_s);
    chk({p, "_we"}, 32'(rf_we), 32'(x_we));
    chk({p, "_addr"}, 32'(rf_addr), 32'(x_a));
    chk({p, "_data"}, rf_data, x_d);
    chk({p, "_rdy"}, 32'(mc_ready), 32'(x_r));
    chk({p, "_haz"}, 32'(dec_hazard), 32'(x_h));
    chk({p, "_stall"}, 32'(pipe_stall), 32'(x_s));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_in();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  bit [31:0]   m_pend;
  int          lost;
  logic        cur_v;
  logic [4:0]  cur_rd;
  logic [31:0] cur_d;
  logic        e_force, e_gmc, e_gwb, e_haz, e_we;
  logic [4:0]  e_addr;
  logic [31:0] e_data;

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = '0;

    // Outputs must be quiet in reset even with requests asserted.
    rst_n = 1'b0;
    drive(1, 7, 32'h11, 1, 3, 32'h22, 1, 4, 4, 4);
    #2;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle_in();

    tbl[0]  = mkv(1,7,'hAA, 0,0,0,   0,0, 0,0, 1,7,'hAA, 0,0,0);
    tbl[1]  = mkv(0,0,0, 1,3,'h55,   0,0, 0,0, 1,3,'h55, 1,0,0);
    tbl[2]  = mkv(0,0,0, 0,0,0,      1,9, 0,0, 0,0,0,    0,0,0);
    tbl[3]  = mkv(0,0,0, 0,0,0,      0,0, 0,9, 0,0,0,    0,1,0);
    tbl[4]  = mkv(0,0,0, 1,9,'h99,   0,0, 0,9, 1,9,'h99, 1,1,0);
    tbl[5]  = mkv(0,0,0, 0,0,0,      0,0, 0,9, 0,0,0,    0,0,0);
    tbl[6]  = mkv(0,0,0, 0,0,0,      1,0, 0,0, 0,0,0,    0,0,0);
    tbl[7]  = mkv(0,0,0, 0,0,0,      1,0, 0,0, 0,0,0,    0,0,0);
    tbl[8]  = mkv(0,0,0, 1,5,'h5A,   1,5, 0,0, 1,5,'h5A, 1,0,0);
    tbl[9]  = mkv(0,0,0, 0,0,0,      0,0, 5,0, 0,0,0,    0,1,0);
    tbl[10] = mkv(0,0,0, 1,0,'h77,   0,0, 5,0, 0,0,'h77, 1,1,0);
    tbl[11] = mkv(0,0,0, 0,0,0,      1,5, 0,0, 0,0,0,    0,1,0);
    tbl[12] = mkv(0,0,0, 1,5,'h123,  0,0, 0,0, 1,5,'h123,1,0,0);
    tbl[13] = mkv(0,0,0, 0,0,0,      0,0, 5,0, 0,0,0,    0,0,0);
    tbl[14] = mkv(1,0,'hBB, 0,0,0,   0,0, 0,0, 0,0,'hBB, 0,0,0);

    for (int i = 0; i < 15; i++) begin
      step();
      drive(tbl[i].wb_we, tbl[i].wb_rd, tbl[i].wb_data,
            tbl[i].mc_valid, tbl[i].mc_rd, tbl[i].mc_data,
            tbl[i].issue, tbl[i].issue_rd,
            tbl[i].rs1, tbl[i].rs2);
      #1;
      chk_all($sformatf("tbl%0d", i), tbl[i].e_we,
              tbl[i].e_addr, tbl[i].e_data, tbl[i].e_rdy,
              tbl[i].e_haz, tbl[i].e_stall);
    end
    step();
    idle_in();
    chk("rf_x3", regs[3], 32'h55);
    chk("rf_x7", regs[7], 32'hAA);
    chk("rf_x5", regs[5], 32'h123);
    chk("rf_x0", regs[0], 32'h0);

    // Continuous contention: WB wins LIMIT+1 cycles, then FORCE.
    for (int c = 0; c <= LIMIT + 2; c++) begin
      step();
      drive(1, 5'(c + 1), 32'(c), (c <= LIMIT + 1), 20,
            32'hDEAD, 0, 0, 0, 0);
      #1;
      if (c <= LIMIT)
        chk_all($sformatf("starve%0d", c), 1, 5'(c + 1),
                32'(c), 0, 0, 0);
      else if (c == LIMIT + 1)
        chk_all("starve_force", 1, 20, 32'hDEAD, 1, 0, 1);
      else
        chk_all("starve_after", 1, 5'(c + 1), 32'(c), 0, 0, 0);
    end

    // Async reset while in FORCE with a pending register.
    step();
    drive(0, 0, 0, 0, 0, 0, 1, 12, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 12, 0);
    #1;
    chk("pend12_set", 32'(dec_hazard), 1);
    for (int c = 0; c <= LIMIT + 1; c++) begin
      step();
      drive(1, 6, 32'h66, 1, 13, 32'h13, 0, 0, 0, 0);
    end
    #1;
    chk("prerst_stall", 32'(pipe_stall), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstforce_stall", 32'(pipe_stall), 0);
    chk("rstforce_we", 32'(rf_we), 0);
    chk("rstforce_rdy", 32'(mc_ready), 0);
    idle_in();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();
    drive(1, 6, 32'h66, 1, 13, 32'h13, 0, 0, 12, 0);
    #1;
    chk_all("postrst", 1, 6, 32'h66, 0, 0, 0);

    do_reset();

    // Randomized traffic against a rule-level model.
    m_pend = '0;
    lost = 0;
    cur_v = 1'b0;
    cur_rd = '0;
    cur_d = '0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (!cur_v && $urandom_range(0, 2) != 0) begin
        cur_v  = 1'b1;
        cur_rd = 5'($urandom_range(0, 15));
        cur_d  = $urandom;
      end
      drive(($urandom_range(0, 3) != 0),
            5'($urandom_range(0, 15)), $urandom,
            cur_v, cur_rd, cur_d,
            ($urandom_range(0, 3) == 0),
            5'($urandom_range(0, 15)),
            5'($urandom_range(0, 15)),
            5'($urandom_range(0, 15)));
      #1;
      e_force = (lost == LIMIT + 1);
      e_gmc   = mc_valid && (!wb_we || e_force);
      e_gwb   = wb_we && !e_gmc;
      e_addr  = e_gmc ? mc_rd : (e_gwb ? wb_rd : 5'd0);
      e_data  = e_gmc ? mc_data : (e_gwb ? wb_data : 32'd0);
      e_we    = (e_gmc || e_gwb) && (e_addr != 0);
      e_haz   = m_pend[dec_rs1] || m_pend[dec_rs2]
             || (mc_issue && m_pend[mc_issue_rd]);
      chk_all($sformatf("rnd%0d", i), e_we, e_addr, e_data,
              e_gmc, e_haz, e_force);
      if (e_gmc) m_pend[mc_rd] = 1'b0;
      if (mc_issue && mc_issue_rd != 0)
        m_pend[mc_issue_rd] = 1'b1;
      if (mc_valid && wb_we && !e_force) lost++;
      else lost = 0;
      if (e_gmc) cur_v = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wport_arbiter.md
Name: rf_wport_arbiter

Overview:
- Shares the register file's single write port between the pipeline writeback stage (WB) and a multi-cycle execution unit (MCU: divider / long-latency load).
- Keeps a per-register pending scoreboard of outstanding MCU destinations, so decode can stall on true dependencies.
- Sits between the WB stage, the MCU result interface and the register file write port (RegWrite/addr_rd/data_rd).
- WB wins by default; an anti-starvation FSM freezes the pipeline for one cycle when the MCU has waited too long.

Parameters:
- NUM_REG, 32, number of architectural registers
- REG_ADDR_WIDTH, 5, register index width
- REG_WIDTH, 32, data width
- STARVE_LIMIT, 4, cycles the MCU may wait before the pipeline is forced to stall (must be >= 1)

Ports:
- clk  in  1  clock; state updates on posedge
- rst_n  in  1  reset, asynchronous, active-low
- wb_we  in  1  WB stage requests a register write
- wb_rd  in  REG_ADDR_WIDTH  WB destination
- wb_data  in  REG_WIDTH  WB result
- mc_valid  in  1  MCU result valid; held stable until accepted
- mc_rd  in  REG_ADDR_WIDTH  MCU destination
- mc_data  in  REG_WIDTH  MCU result
- mc_ready  out  1  MCU result accepted this cycle
- mc_issue  in  1  decode issues an MCU op this cycle
- mc_issue_rd  in  REG_ADDR_WIDTH  destination of the issued op
- dec_rs1  in  REG_ADDR_WIDTH  decode source 1
- dec_rs2  in  REG_ADDR_WIDTH  decode source 2
- dec_hazard  out  1  rs1, rs2 or mc_issue_rd is pending
- pipe_stall  out  1  freeze the pipeline (WB must hold its request)
- rf_we  out  1  to register file RegWrite
- rf_addr  out  REG_ADDR_WIDTH  to register file addr_rd
- rf_data  out  REG_WIDTH  to register file data_rd

Behaviour:
- Write port outputs are combinational. The register file samples them on negedge, so they must be settled within the posedge-to-negedge half cycle.
- grant_mc = mc_valid & (~wb_we | state==FORCE). grant_wb = wb_we & ~grant_mc.
- mc_ready = grant_mc.
- rf_addr/rf_data come from the granted source. rf_we = (grant_wb | grant_mc) & (rf_addr != 0). When there is no grant, rf_we=0 and rf_addr/rf_data=0.
- A write to x0 is still granted and handshaken (mc_ready=1) but is not written (rf_we=0).
- FSM states:
  - IDLE: cnt=0. If mc_valid & wb_we -> WAIT with cnt=1.
  - WAIT: if mc_valid & ~wb_we (accepted) -> IDLE. Else if cnt==STARVE_LIMIT -> FORCE. Else cnt++. If mc_valid drops (protocol violation) -> IDLE.
  - FORCE: pipe_stall=1 (combinational, this cycle only); MCU granted; -> IDLE, cnt=0.
- pipe_stall is 1 only in FORCE. It is 0 in every other state and during reset.
- Scoreboard pend[NUM_REG-1:0], updated on posedge:
  - Set pend[mc_issue_rd] on mc_issue & mc_issue_rd!=0.
  - Clear pend[mc_rd] on grant_mc.
  - Same index set and cleared in the same cycle: set wins.
  - pend[0] is always 0.
- dec_hazard = pend[dec_rs1] | pend[dec_rs2] | (mc_issue & pend[mc_issue_rd]), combinational. Issuing to a pending rd is a WAW hazard that decode must stall on.
- A WB write to a pending register does not clear pend; the MCU result written later is the architecturally correct one, as issue order guarantees.
- Reset (async, any state, including mid-FORCE): state=IDLE, cnt=0, pend=0. All outputs are 0 while rst_n=0.
- Latency: write data is committed in the same cycle as the grant, at that cycle's negedge. The MCU waits at most STARVE_LIMIT+1 cycles from first valid under continuous WB traffic.

Decomposition:
- Package rf_pkg: REG_ADDR_WIDTH, REG_WIDTH, NUM_REG constants; FSM state enum {IDLE, WAIT, FORCE}.
- One sub-module: rf_scoreboard (pend vector, set/clear logic, hazard lookup).
- Arbiter FSM and write mux stay in the top module.

Test Plan:
- wb_we=1, rd=7, data=0xAA, mc_valid=0 -> rf_we=1, rf_addr=7, rf_data=0xAA, mc_ready=0, pipe_stall=0.
- mc_valid=1 (rd=3, data=0x55), wb_we=0 -> mc_ready=1 same cycle, register 3 = 0x55 after negedge, state stays IDLE.
- wb_we=1 and mc_valid=1 held continuously, STARVE_LIMIT=4 -> cycles 0..4 grant WB; cycle 5 FORCE with pipe_stall=1, mc_ready=1, rf_addr=mc_rd; cycle 6 IDLE, pipe_stall=0.
- mc_issue rd=9 -> next cycle dec_rs2=9 gives dec_hazard=1. MCU write to 9 accepted -> following cycle dec_hazard=0. mc_issue rd=0 -> pend stays 0.
- mc_issue rd=5 in the same cycle as grant_mc with mc_rd=5 -> pend[5]=1 afterwards (set wins). mc_valid with mc_rd=0 -> mc_ready=1, rf_we=0.
- rst_n pulled low asynchronously while in FORCE with pend[12]=1 -> immediately pipe_stall=0, rf_we=0, mc_ready=0. After release: state IDLE, dec_hazard=0 for rs1=12.
